aes128_encrypt_iter: RTL and testbench

//  Iterative AES-128 encryption core that consumes the round keys from key_expansion.

---
 rtl/aes128_encrypt_iter_pkg.sv | 52 +++++
 rtl/aes128_encrypt_iter_round.sv | 53 +++++
 rtl/aes128_encrypt_iter_sbox.sv | 11 +
 rtl/key_expansion.sv | 30 +++
 rtl/aes128_encrypt_iter.sv | 84 ++++++++
 tb/tb_aes128_encrypt_iter.sv | 217 +++++++++++++++++++++
 6 files changed

// File: rtl/aes128_encrypt_iter_pkg.sv
// rtl/aes128_encrypt_iter_pkg.sv - AES constants, types and byte-level helper functions
package aes128_encrypt_iter_pkg;

  localparam int AES_NR = 10;

  typedef logic [127:0] state_t;

  // FIPS-197 S-box, entry 0 in the most significant byte
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Round constants for rounds 1..10, round 1 in the most significant byte
  localparam logic [79:0] RCON = 80'h01020408102040801b36;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    int idx;
    idx = 2047 - 8 * int'(b);
    return SBOX[idx -: 8];
  endfunction

  function automatic logic [7:0] rcon(input int r);
    return RCON[79 - 8 * (r - 1) -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Bit offset of the top bit of byte i (byte 0 at [127:120])
  function automatic int byte_msb(input int i);
    return 127 - 8 * i;
  endfunction

  // Column-major byte index for (column, row)
  function automatic int byte_idx(input int col, input int row);
    return col * 4 + row;
  endfunction

endpackage

// File: rtl/aes128_encrypt_iter_round.sv
// rtl/aes128_encrypt_iter_round.sv - one combinational AES encryption round
module aes_round
  import aes128_encrypt_iter_pkg::*;
(
  input  state_t state_in,
  input  state_t round_key,
  input  logic   last,
  output state_t state_out
);

  logic [7:0] sb [16];
  state_t     sr;
  state_t     mc;

  genvar g;
  generate
    for (g = 0; g < 16; g++) begin : g_sbox
      aes_sbox u_sbox (.a(state_in[127 - 8 * g -: 8]), .y(sb[g]));
    end
  endgenerate

  // ShiftRows rotates row r left by r columns; MixColumns is skipped on the final round
  always_comb begin
    logic [7:0] a0, a1, a2, a3;
    sr = '0;
    mc = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[byte_msb(byte_idx(c, r)) -: 8] = sb[byte_idx((c + r) % 4, r)];
      end
    end
    for (int c = 0; c < 4; c++) begin
      a0 = sr[byte_msb(byte_idx(c, 0)) -: 8];
      a1 = sr[byte_msb(byte_idx(c, 1)) -: 8];
      a2 = sr[byte_msb(byte_idx(c, 2)) -: 8];
      a3 = sr[byte_msb(byte_idx(c, 3)) -: 8];
      if (last) begin
        mc[byte_msb(byte_idx(c, 0)) -: 8] = a0;
        mc[byte_msb(byte_idx(c, 1)) -: 8] = a1;
        mc[byte_msb(byte_idx(c, 2)) -: 8] = a2;
        mc[byte_msb(byte_idx(c, 3)) -: 8] = a3;
      end else begin
        mc[byte_msb(byte_idx(c, 0)) -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        mc[byte_msb(byte_idx(c, 1)) -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        mc[byte_msb(byte_idx(c, 2)) -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        mc[byte_msb(byte_idx(c, 3)) -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
    end
  end

  assign state_out = mc ^ round_key;

endmodule

// File: rtl/aes128_encrypt_iter_sbox.sv
// rtl/aes128_encrypt_iter_sbox.sv - single AES S-box lookup
module aes_sbox
  import aes128_encrypt_iter_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);

  assign y = sbox(a);

endmodule

// File: rtl/key_expansion.sv
// rtl/key_expansion.sv - combinational AES-128 round key for a selected round index
module key_expansion
  import aes128_encrypt_iter_pkg::*;
(
  input  logic [127:0] key,
  input  logic [3:0]   round,
  output logic [127:0] op_key
);

  logic [31:0] w0, w1, w2, w3, t;

  // Unrolled schedule; the word set matching the requested round is captured
  always_comb begin
    w0 = key[127:96];
    w1 = key[95:64];
    w2 = key[63:32];
    w3 = key[31:0];
    t = 32'h0;
    op_key = key;
    for (int r = 1; r <= AES_NR; r++) begin
      t = sub_word({w3[23:0], w3[31:24]}) ^ {rcon(r), 24'h0};
      w0 = w0 ^ t;
      w1 = w1 ^ w0;
      w2 = w2 ^ w1;
      w3 = w3 ^ w2;
      if (round == 4'(r)) op_key = {w0, w1, w2, w3};
    end
  end

endmodule

// File: rtl/aes128_encrypt_iter.sv
// rtl/aes128_encrypt_iter.sv - iterative AES-128 encryption core, one round per clock
module aes128_encrypt_iter
  import aes128_encrypt_iter_pkg::*;
#(
  parameter int NR              = AES_NR,
  parameter bit CLR_KEY_ON_DONE = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] key,
  input  logic [127:0] plaintext,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext,
  output logic [127:0] ke_key,
  output logic [3:0]   ke_round,
  input  logic [127:0] ke_op_key,
  output logic         busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROUND = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0] state;
  logic [3:0] rnd;
  state_t     state_q;
  state_t     key_q;
  state_t     round_out;
  logic       last_round;

  assign last_round = (rnd == 4'(NR));

  aes_round u_round (
    .state_in  (state_q),
    .round_key (ke_op_key),
    .last      (last_round),
    .state_out (round_out)
  );

  assign in_ready   = (state == S_IDLE);
  assign out_valid  = (state == S_DONE);
  assign busy       = (state == S_ROUND) || (state == S_DONE);
  assign ke_round   = (state == S_ROUND) ? rnd : 4'd0;
  assign ke_key     = key_q;
  assign ciphertext = state_q;

  // Sequencer: accept with whitening, iterate rounds, hold result until taken
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      rnd     <= 4'd0;
      state_q <= '0;
      key_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            key_q   <= key;
            state_q <= plaintext ^ key;
            rnd     <= 4'd1;
            state   <= S_ROUND;
          end
        end
        S_ROUND: begin
          state_q <= round_out;
          if (last_round) state <= S_DONE;
          else            rnd   <= rnd + 4'd1;
        end
        S_DONE: begin
          if (out_ready) begin
            state <= S_IDLE;
            rnd   <= 4'd0;
            if (CLR_KEY_ON_DONE) key_q <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_encrypt_iter.sv
// tb/tb_aes128_encrypt_iter.sv - directed-vector bench for aes128_encrypt_iter with key_expansion
module tb_aes128_encrypt_iter;

  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT2 = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] key = '0;
  logic [127:0] plaintext = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] ciphertext;
  logic [127:0] ke_key;
  logic [3:0]   ke_round;
  logic [127:0] ke_op_key;
  logic         busy;

  int chk  = 0;
  int pass = 0;

  always #5 clk = ~clk;

  aes128_encrypt_iter dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .key        (key),
    .plaintext  (plaintext),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ciphertext (ciphertext),
    .ke_key     (ke_key),
    .ke_round   (ke_round),
    .ke_op_key  (ke_op_key),
    .busy       (busy)
  );

  key_expansion u_ke (
    .key    (ke_key),
    .round  (ke_round),
    .op_key (ke_op_key)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [127:0] k, input logic [127:0] p);
    key = k;
    plaintext = p;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      step();
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else pass++;
    chk++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else pass++;
    chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass++;
    chk++; if (ke_round !== 4'd0) $display("FAIL reset_ke_round: got %0d want 0", ke_round); else pass++;
    chk++; if (ciphertext !== 128'h0) $display("FAIL reset_ciphertext: got %h want 0", ciphertext); else pass++;
    chk++; if (ke_key !== 128'h0) $display("FAIL reset_ke_key: got %h want 0", ke_key); else pass++;
  endtask

  task automatic test_vector1;
    int c;
    accept(K1, P1);
    chk++; if (ke_key !== K1) $display("FAIL v1_ke_key: got %h want %h", ke_key, K1); else pass++;
    wait_out(c);
    chk++; if (c !== 10) $display("FAIL v1_latency: got %0d want 10", c); else pass++;
    chk++; if (ciphertext !== CT1) $display("FAIL v1_ct: got %h want %h", ciphertext, CT1); else pass++;
    chk++; if (in_ready !== 1'b0 || busy !== 1'b1) $display("FAIL v1_done_flags: got in_ready=%b busy=%b want 0 1", in_ready, busy); else pass++;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL v1_idle: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid); else pass++;
    chk++; if (ke_key !== 128'h0) $display("FAIL v1_key_cleared: got %h want 0", ke_key); else pass++;
  endtask

  task automatic test_vector2;
    int bad;
    bad = 0;
    accept(K2, P2);
    for (int r = 1; r <= 10; r++) begin
      if (ke_round !== 4'(r)) bad++;
      step();
    end
    chk++; if (bad !== 0) $display("FAIL v2_ke_round_seq: got %0d bad steps want 0", bad); else pass++;
    chk++; if (ke_round !== 4'd0) $display("FAIL v2_ke_round_done: got %0d want 0", ke_round); else pass++;
    chk++; if (out_valid !== 1'b1) $display("FAIL v2_out_valid: got %b want 1", out_valid); else pass++;
    chk++; if (ciphertext !== CT2) $display("FAIL v2_ct: got %h want %h", ciphertext, CT2); else pass++;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_stall;
    int c;
    int bad;
    bad = 0;
    accept(K1, P1);
    wait_out(c);
    chk++; if (c !== 10) $display("FAIL stall_latency: got %0d want 10", c); else pass++;
    for (int i = 0; i < 20; i++) begin
      if (ciphertext !== CT1 || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
      step();
    end
    chk++; if (bad !== 0) $display("FAIL stall_hold: got %0d unstable cycles want 0", bad); else pass++;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL stall_release: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid); else pass++;
  endtask

  task automatic test_ignore_input;
    int c;
    accept(K1, P1);
    step();
    step();
    key = K2;
    plaintext = P2;
    in_valid = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    chk++; if (ke_key !== K1) $display("FAIL ignore_key: got %h want %h", ke_key, K1); else pass++;
    wait_out(c);
    chk++; if (ciphertext !== CT1 || out_valid !== 1'b1) $display("FAIL ignore_ct: got %h valid=%b want %h", ciphertext, out_valid, CT1); else pass++;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    int c;
    accept(K1, P1);
    for (int i = 0; i < 4; i++) step();
    chk++; if (ke_round !== 4'd5) $display("FAIL rstmid_round: got %0d want 5", ke_round); else pass++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL rstmid_flags: got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready); else pass++;
    chk++; if (ke_round !== 4'd0 || ke_key !== 128'h0) $display("FAIL rstmid_ke: got round=%0d key=%h want 0 0", ke_round, ke_key); else pass++;
    chk++; if (ciphertext !== 128'h0 || busy !== 1'b0) $display("FAIL rstmid_state: got ct=%h busy=%b want 0 0", ciphertext, busy); else pass++;
    accept(K2, P2);
    wait_out(c);
    chk++; if (c !== 10 || ciphertext !== CT2) $display("FAIL rstmid_fresh: got lat=%0d ct=%h want 10 %h", c, ciphertext, CT2); else pass++;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    int c;
    int c2;
    int acc2;
    bit got1;
    got1 = 1'b0;
    acc2 = -1;
    c = 0;
    accept(K1, P1);
    key = K2;
    plaintext = P2;
    in_valid = 1'b1;
    out_ready = 1'b1;
    while (c < 40 && acc2 < 0) begin
      if (out_valid && !got1) begin
        got1 = 1'b1;
        chk++; if (ciphertext !== CT1 || c !== 10) $display("FAIL b2b_first: got ct=%h at %0d want %h at 10", ciphertext, c, CT1); else pass++;
      end
      if (in_ready) acc2 = c + 1;
      step();
      c++;
    end
    in_valid = 1'b0;
    chk++; if (acc2 !== 12) $display("FAIL b2b_interval: got %0d want 12", acc2); else pass++;
    wait_out(c2);
    chk++; if (c2 !== 10 || ciphertext !== CT2) $display("FAIL b2b_second: got lat=%0d ct=%h want 10 %h", c2, ciphertext, CT2); else pass++;
    step();
    out_ready = 1'b0;
    chk++; if (in_ready !== 1'b1) $display("FAIL b2b_idle: got %b want 1", in_ready); else pass++;
  endtask

  initial begin
    test_reset();
    test_vector1();
    test_vector2();
    test_stall();
    test_ignore_input();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

endmodule
